// File: rtl/uart_tx_arbiter_if.sv
// ============================================================================
// Module  : uart_tx_arbiter_if
// Purpose : Requester-side request/data bundle and UART transmitter
//           handshake for the UART transmit arbiter.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface uart_tx_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 8
);

  logic [NREQ-1:0]        req;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        ack;
  logic                   tx_start;
  logic [DATA_W-1:0]      tx_data;
  logic                   busy;
  logic [1:0]             active_id;
  logic                   active;
  logic                   timeout_err;

  // Master is the environment side: the requesters plus the UART busy flag.
  modport master (
    output req,
    output req_data,
    output busy,
    input  ack,
    input  tx_start,
    input  tx_data,
    input  active_id,
    input  active,
    input  timeout_err
  );

  modport slave (
    input  req,
    input  req_data,
    input  busy,
    output ack,
    output tx_start,
    output tx_data,
    output active_id,
    output active,
    output timeout_err
  );

endinterface

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module  : uart_tx_arbiter
// Purpose : Round-robin arbiter that shares one UART transmitter among
//           NREQ byte requesters, with a busy-rise timeout.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 8,
  parameter int TMO    = 15
) (
  input  wire logic        clk,
  input  wire logic        rst,
  uart_tx_arbiter_if.slave bus
);

  localparam int c_ID_W  = $clog2(NREQ);
  localparam int c_CNT_W = $clog2(TMO + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t              r_state;
  logic [c_ID_W-1:0]   r_rr_ptr;
  logic [c_CNT_W-1:0]  r_cnt;
  logic                r_tx_start;
  logic [NREQ-1:0]     r_ack;
  logic [DATA_W-1:0]   r_tx_data;
  logic [c_ID_W-1:0]   r_active_id;
  logic                r_active;
  logic                r_timeout_err;

  logic [NREQ-1:0]     w_rot;
  logic [c_ID_W-1:0]   w_off;
  logic [c_ID_W-1:0]   w_grant_id;
  logic [NREQ-1:0]     w_grant_oh;
  logic [DATA_W-1:0]   w_grant_data;
  logic                w_any_req;
  logic [c_CNT_W-1:0]  w_cnt_nxt;

  // Requests rotated so that bit 0 is the requester at rr_ptr; the lowest
  // set bit of w_rot is then the next one in round-robin order.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
      assign w_rot[gi] = bus.req[r_rr_ptr + c_ID_W'(gi)];
    end
  endgenerate

  always_comb begin
    w_off = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_off = c_ID_W'(k);
      end
    end
  end

  assign w_any_req    = |bus.req;
  assign w_grant_id   = r_rr_ptr + w_off;
  assign w_grant_oh   = {{(NREQ-1){1'b0}}, 1'b1} << w_grant_id;
  assign w_grant_data = bus.req_data[w_grant_id*DATA_W +: DATA_W];
  assign w_cnt_nxt    = r_cnt + c_CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_rr_ptr      <= '0;
      r_cnt         <= '0;
      r_tx_start    <= 1'b0;
      r_ack         <= '0;
      r_tx_data     <= '0;
      r_active_id   <= '0;
      r_active      <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_tx_start    <= 1'b0;
      r_ack         <= '0;
      r_timeout_err <= 1'b0;
      case (r_state)
        IDLE: begin
          // Pulses are registered here so they are visible for the whole
          // ISSUE cycle that follows.
          if (w_any_req) begin
            r_tx_data   <= w_grant_data;
            r_active_id <= w_grant_id;
            r_tx_start  <= 1'b1;
            r_ack       <= w_grant_oh;
            r_active    <= 1'b1;
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          r_rr_ptr <= r_active_id + c_ID_W'(1);
          r_cnt    <= '0;
          r_state  <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (bus.busy) begin
            r_state <= WAIT_DONE;
          end else begin
            r_cnt <= w_cnt_nxt;
            if (w_cnt_nxt == c_CNT_W'(TMO)) begin
              r_timeout_err <= 1'b1;
              r_active      <= 1'b0;
              r_state       <= IDLE;
            end
          end
        end
        WAIT_DONE: begin
          if (!bus.busy) begin
            r_active <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: begin
          r_active <= 1'b0;
          r_state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.tx_start    = r_tx_start;
  assign bus.ack         = r_ack;
  assign bus.tx_data     = r_tx_data;
  assign bus.active_id   = r_active_id;
  assign bus.active      = r_active;
  assign bus.timeout_err = r_timeout_err;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// Module  : tb_uart_tx_arbiter
// Purpose : Scoreboard bench for uart_tx_arbiter: grants, round-robin order,
//           timeout and asynchronous reset behaviour.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

  localparam int NREQ   = 4;
  localparam int DATA_W = 8;
  localparam int TMO    = 15;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } grant_t;

  logic   clk = 1'b0;
  logic   rst;
  grant_t exp_q[$];
  int     n_total = 0;
  int     n_bad   = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NREQ(NREQ), .DATA_W(DATA_W)) bus ();

  uart_tx_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .TMO(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Waits (bounded) for the next negedge that shows tx_start high.
  task automatic wait_start(output bit ok, output int waited);
    ok = 1'b0;
    waited = 0;
    while (!ok && waited < 64) begin
      @(negedge clk);
      waited++;
      if (bus.tx_start === 1'b1) ok = 1'b1;
    end
  endtask

  // Drops the acked request, raises busy after dly cycles, holds it len cycles.
  task automatic serve(input int dly, input int len);
    bus.req = bus.req & ~bus.ack;
    repeat (dly) @(negedge clk);
    bus.busy = 1'b1;
    repeat (len) @(negedge clk);
    bus.busy = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = '0;
    bus.req_data = '0;
    bus.busy = 1'b0;
    repeat (3) @(negedge clk);
    n_total++; if (bus.tx_start !== 1'b0) begin n_bad++; $display("FAIL rst_tx_start: got %b want 0", bus.tx_start); end
    n_total++; if (bus.ack !== 4'b0000) begin n_bad++; $display("FAIL rst_ack: got %b want 0000", bus.ack); end
    n_total++; if (bus.tx_data !== 8'h00) begin n_bad++; $display("FAIL rst_tx_data: got %h want 00", bus.tx_data); end
    n_total++; if (bus.active_id !== 2'd0) begin n_bad++; $display("FAIL rst_active_id: got %0d want 0", bus.active_id); end
    n_total++; if (bus.active !== 1'b0) begin n_bad++; $display("FAIL rst_active: got %b want 0", bus.active); end
    n_total++; if (bus.timeout_err !== 1'b0) begin n_bad++; $display("FAIL rst_timeout: got %b want 0", bus.timeout_err); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_total++; if (bus.active !== 1'b0 || bus.tx_start !== 1'b0) begin n_bad++; $display("FAIL idle_noreq: got active=%b tx_start=%b want 0 0", bus.active, bus.tx_start); end
  endtask

  task automatic test_contention();
    bit ok;
    int waited;
    grant_t e;
    logic [3:0] exp_ack;
    bus.req_data = {8'h40, 8'h30, 8'h20, 8'h10};
    bus.req = 4'b1111;
    exp_q.push_back('{id: 2'd0, data: 8'h10});
    exp_q.push_back('{id: 2'd1, data: 8'h20});
    exp_q.push_back('{id: 2'd2, data: 8'h30});
    exp_q.push_back('{id: 2'd3, data: 8'h40});
    for (int g = 0; g < 4; g++) begin
      wait_start(ok, waited);
      n_total++;
      if (!ok || exp_q.size() == 0) begin n_bad++; $display("FAIL cont_start: got no grant %0d want tx_start", g); return; end
      e = exp_q.pop_front();
      exp_ack = 4'b0001 << e.id;
      n_total++; if (bus.tx_data !== e.data) begin n_bad++; $display("FAIL cont_data: got %h want %h", bus.tx_data, e.data); end
      n_total++; if (bus.active_id !== e.id) begin n_bad++; $display("FAIL cont_id: got %0d want %0d", bus.active_id, e.id); end
      n_total++; if (bus.ack !== exp_ack) begin n_bad++; $display("FAIL cont_ack: got %b want %b", bus.ack, exp_ack); end
      serve(1, 3);
      n_total++; if (bus.active !== 1'b0 || bus.tx_start !== 1'b0) begin n_bad++; $display("FAIL cont_gap: got active=%b tx_start=%b want 0 0", bus.active, bus.tx_start); end
    end
  endtask

  task automatic test_single();
    bit ok;
    int waited;
    int starts;
    int unstable;
    grant_t e;
    bus.req_data = {8'h00, 8'h00, 8'hA5, 8'h00};
    bus.req = 4'b0010;
    exp_q.push_back('{id: 2'd1, data: 8'hA5});
    wait_start(ok, waited);
    n_total++;
    if (!ok || exp_q.size() == 0) begin n_bad++; $display("FAIL single_start: got none want tx_start"); return; end
    e = exp_q.pop_front();
    n_total++; if (waited !== 1) begin n_bad++; $display("FAIL single_latency: got %0d want 1", waited); end
    n_total++; if (bus.tx_data !== e.data) begin n_bad++; $display("FAIL single_data: got %h want %h", bus.tx_data, e.data); end
    n_total++; if (bus.active_id !== e.id) begin n_bad++; $display("FAIL single_id: got %0d want %0d", bus.active_id, e.id); end
    n_total++; if (bus.ack !== 4'b0010) begin n_bad++; $display("FAIL single_ack: got %b want 0010", bus.ack); end
    bus.req = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    bus.busy = 1'b1;
    starts = 0;
    unstable = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.tx_start === 1'b1) starts++;
      if (bus.tx_data !== 8'hA5 || bus.active_id !== 2'd1 || bus.active !== 1'b1) unstable++;
    end
    bus.busy = 1'b0;
    @(negedge clk);
    n_total++; if (starts !== 0) begin n_bad++; $display("FAIL single_extra_start: got %0d want 0", starts); end
    n_total++; if (unstable !== 0) begin n_bad++; $display("FAIL single_stable: got %0d bad cycles want 0", unstable); end
    n_total++; if (bus.active !== 1'b0) begin n_bad++; $display("FAIL single_idle: got %b want 0", bus.active); end
  endtask

  task automatic test_fairness();
    bit ok;
    int waited;
    grant_t e;
    logic [3:0] exp_ack;
    bus.req_data = {8'h66, 8'h33, 8'h00, 8'h55};
    bus.req = 4'b0100;
    exp_q.push_back('{id: 2'd2, data: 8'h33});
    for (int g = 0; g < 3; g++) begin
      wait_start(ok, waited);
      n_total++;
      if (!ok || exp_q.size() == 0) begin n_bad++; $display("FAIL fair_start: got no grant %0d want tx_start", g); return; end
      e = exp_q.pop_front();
      exp_ack = 4'b0001 << e.id;
      n_total++; if (bus.active_id !== e.id) begin n_bad++; $display("FAIL fair_id: got %0d want %0d", bus.active_id, e.id); end
      n_total++; if (bus.tx_data !== e.data) begin n_bad++; $display("FAIL fair_data: got %h want %h", bus.tx_data, e.data); end
      n_total++; if (bus.ack !== exp_ack) begin n_bad++; $display("FAIL fair_ack: got %b want %b", bus.ack, exp_ack); end
      serve(1, 2);
      if (g == 0) begin
        // Requester 2 was just served, so 3 must win over 0.
        bus.req = 4'b1001;
        exp_q.push_back('{id: 2'd3, data: 8'h66});
        exp_q.push_back('{id: 2'd0, data: 8'h55});
      end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int waited;
    int k;
    int starts;
    grant_t e;
    bus.req_data = {8'h00, 8'h77, 8'h00, 8'h00};
    bus.req = 4'b0100;
    exp_q.push_back('{id: 2'd2, data: 8'h77});
    wait_start(ok, waited);
    n_total++;
    if (!ok || exp_q.size() == 0) begin n_bad++; $display("FAIL tmo_start: got none want tx_start"); return; end
    e = exp_q.pop_front();
    n_total++; if (bus.tx_data !== e.data) begin n_bad++; $display("FAIL tmo_data: got %h want %h", bus.tx_data, e.data); end
    bus.req = 4'b0000;
    k = 0;
    while (k < 40) begin
      @(negedge clk);
      k++;
      if (bus.timeout_err === 1'b1) break;
    end
    // One ISSUE cycle, then TMO cycles of waiting for busy.
    n_total++; if (k !== TMO + 1) begin n_bad++; $display("FAIL tmo_delay: got %0d want %0d", k, TMO + 1); end
    n_total++; if (bus.active !== 1'b0) begin n_bad++; $display("FAIL tmo_active: got %b want 0", bus.active); end
    @(negedge clk);
    n_total++; if (bus.timeout_err !== 1'b0) begin n_bad++; $display("FAIL tmo_pulse_width: got %b want 0", bus.timeout_err); end
    bus.busy = 1'b1;
    starts = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.active !== 1'b0 || bus.tx_start !== 1'b0) starts++;
    end
    bus.busy = 1'b0;
    n_total++; if (starts !== 0) begin n_bad++; $display("FAIL idle_busy_ignored: got %0d active cycles want 0", starts); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int waited;
    int starts;
    grant_t e;
    bus.req_data = {8'hC3, 8'h00, 8'h00, 8'h5A};
    bus.req = 4'b0001;
    exp_q.push_back('{id: 2'd0, data: 8'h5A});
    wait_start(ok, waited);
    n_total++;
    if (!ok || exp_q.size() == 0) begin n_bad++; $display("FAIL rmid_start: got none want tx_start"); return; end
    e = exp_q.pop_front();
    n_total++; if (bus.tx_data !== e.data) begin n_bad++; $display("FAIL rmid_data: got %h want %h", bus.tx_data, e.data); end
    bus.req = 4'b0000;
    @(negedge clk);
    bus.busy = 1'b1;
    repeat (3) @(negedge clk);
    n_total++; if (bus.active !== 1'b1) begin n_bad++; $display("FAIL rmid_wait_done: got %b want 1", bus.active); end
    rst = 1'b1;
    #1;
    n_total++;
    if (bus.tx_data !== 8'h00 || bus.active !== 1'b0 || bus.active_id !== 2'd0 ||
        bus.ack !== 4'b0000 || bus.tx_start !== 1'b0 || bus.timeout_err !== 1'b0) begin
      n_bad++;
      $display("FAIL rmid_async_clear: got data=%h active=%b id=%0d ack=%b start=%b tmo=%b want all 0",
               bus.tx_data, bus.active, bus.active_id, bus.ack, bus.tx_start, bus.timeout_err);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus.busy = 1'b0;
    bus.req = 4'b1000;
    exp_q.push_back('{id: 2'd3, data: 8'hC3});
    wait_start(ok, waited);
    n_total++;
    if (!ok || exp_q.size() == 0) begin n_bad++; $display("FAIL rmid_regrant: got none want tx_start"); return; end
    e = exp_q.pop_front();
    n_total++; if (bus.active_id !== e.id || bus.tx_data !== e.data) begin n_bad++; $display("FAIL rmid_grant: got id=%0d data=%h want id=%0d data=%h", bus.active_id, bus.tx_data, e.id, e.data); end
    n_total++; if (bus.ack !== 4'b1000) begin n_bad++; $display("FAIL rmid_ack: got %b want 1000", bus.ack); end
    bus.req = 4'b0000;
    @(negedge clk);
    bus.busy = 1'b1;
    starts = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.tx_start === 1'b1) starts++;
    end
    bus.busy = 1'b0;
    repeat (3) @(negedge clk);
    n_total++; if (starts !== 0 || bus.active !== 1'b0) begin n_bad++; $display("FAIL rmid_once: got starts=%0d active=%b want 0 0", starts, bus.active); end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single();
    test_fairness();
    test_timeout();
    test_reset_mid();
    n_total++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL scoreboard_left: got %0d want 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
